// File: rtl/chip8_pkg.sv
// chip8_pkg: shared request types, control addresses and display FSM
// states for the CHIP-8 framebuffer block.
package chip8_pkg;

   localparam int FB_BYTES  = 256;
   localparam int FB_ADDR_W = $clog2(FB_BYTES);

   localparam logic [7:0] FB_CTRL_CLEAR     = 8'd0;
   localparam logic [7:0] FB_CTRL_COLLISION = 8'd1;

   typedef enum logic [1:0] {
      RAM     = 2'b00,
      FB      = 2'b01,
      FB_CTRL = 2'b10,
      RSVD    = 2'b11
   } mem_type_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT1,
      RD_WAIT2,
      RMW_WAIT1,
      RMW_WRITE,
      CLEAR,
      CTRL_RESP
   } fb_state_t;

endpackage

// File: rtl/chip8_fb_bram.sv
// chip8_fb_bram: true dual-port byte RAM, two-cycle registered reads.
// Port A reads and writes; port B only reads and sees pre-write data.
module chip8_fb_bram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr_a,
   input  logic          we_a,
   input  logic [7:0]    wdata_a,
   output logic [7:0]    q_a,
   input  logic [AW-1:0] addr_b,
   output logic [7:0]    q_b
);

   logic [7:0] mem [DEPTH];
   logic [7:0] a1;
   logic [7:0] b1;

   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
   end

   // Only the pipeline registers reset; the array keeps its contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a1  <= '0;
         q_a <= '0;
         b1  <= '0;
         q_b <= '0;
      end else begin
         a1  <= mem[addr_a];
         q_a <= a1;
         b1  <= mem[addr_b];
         q_b <= b1;
      end
   end

endmodule

// File: rtl/chip8_framebuffer.sv
// chip8_framebuffer: CHIP-8 64x32 display memory with XOR sprite writes,
// sticky collision flag, screen clear and a pipelined scanout port.
module chip8_framebuffer
   import chip8_pkg::*;
#(
   parameter int FB_BYTES  = 256,
   parameter int FB_ADDR_W = 8
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic [11:0]     proc_addr_in,
   input  logic            proc_we_in,
   input  logic            proc_valid_in,
   input  logic [7:0]      proc_data_in,
   input  mem_type_t       proc_type_in,
   output logic            proc_ready_out,
   output logic            proc_valid_out,
   output logic [7:0]      data_out,
   input  logic            video_valid_in,
   input  logic [7:0]      video_addr_in,
   output logic            video_valid_out,
   output logic [7:0]      video_data_out
);

   fb_state_t            state;
   logic [FB_ADDR_W-1:0] addr_l;
   logic                 we_l;
   logic [7:0]           data_l;
   logic                 ctrl_l;
   logic                 flag;
   logic [FB_ADDR_W-1:0] clr_addr;
   logic                 video_v1;

   logic [FB_ADDR_W-1:0] addr_a;
   logic                 we_a;
   logic [7:0]           wdata_a;
   logic [7:0]           q_a;
   logic                 accept;
   logic [FB_ADDR_W-1:0] req_addr;
   logic                 coll_rd;

   assign req_addr = proc_addr_in[FB_ADDR_W-1:0];
   assign accept   = proc_valid_in & proc_ready_out
                   & (proc_type_in == FB || proc_type_in == FB_CTRL);
   assign coll_rd  = !we_l && addr_l == FB_ADDR_W'(FB_CTRL_COLLISION);

   // Port A reads the incoming address while idle so RMW data lands at T+2.
   always_comb begin
      addr_a  = addr_l;
      we_a    = 1'b0;
      wdata_a = q_a ^ data_l;
      unique case (1'b1)
         state == IDLE:      addr_a = req_addr;
         state == CLEAR: begin
            addr_a  = clr_addr;
            we_a    = 1'b1;
            wdata_a = 8'h00;
         end
         state == RMW_WRITE: we_a = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      data_out = 8'h00;
      unique case (1'b1)
         state == RD_WAIT2:  data_out = q_a;
         state == RMW_WRITE: data_out = q_a & data_l;
         state == CTRL_RESP: if (coll_rd) data_out = {7'b0, flag};
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= IDLE;
         proc_ready_out <= 1'b1;
         proc_valid_out <= 1'b0;
         flag           <= 1'b0;
         addr_l         <= '0;
         we_l           <= 1'b0;
         data_l         <= 8'h00;
         ctrl_l         <= 1'b0;
         clr_addr       <= '0;
      end else begin
         proc_valid_out <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               addr_l         <= req_addr;
               we_l           <= proc_we_in;
               data_l         <= proc_data_in;
               ctrl_l         <= proc_type_in == FB_CTRL;
               clr_addr       <= '0;
               proc_ready_out <= 1'b0;
               if (proc_type_in == FB)
                  state <= proc_we_in ? RMW_WAIT1 : RD_WAIT1;
               else if (proc_we_in &&
                        req_addr == FB_ADDR_W'(FB_CTRL_CLEAR)) begin
                  state <= CLEAR;
                  flag  <= 1'b0;
               end else
                  state <= RD_WAIT1;
            end
            RD_WAIT1: begin
               state          <= ctrl_l ? CTRL_RESP : RD_WAIT2;
               proc_valid_out <= 1'b1;
            end
            RMW_WAIT1: begin
               state          <= RMW_WRITE;
               proc_valid_out <= 1'b1;
            end
            RD_WAIT2: begin
               state          <= IDLE;
               proc_ready_out <= 1'b1;
            end
            RMW_WRITE: begin
               state          <= IDLE;
               proc_ready_out <= 1'b1;
               if ((q_a & data_l) != 8'h00) flag <= 1'b1;
            end
            CTRL_RESP: begin
               state          <= IDLE;
               proc_ready_out <= 1'b1;
               if (coll_rd) flag <= 1'b0;
            end
            CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == FB_ADDR_W'(FB_BYTES - 2))
                  proc_valid_out <= 1'b1;
               if (clr_addr == '1) begin
                  state          <= IDLE;
                  proc_ready_out <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         video_v1        <= 1'b0;
         video_valid_out <= 1'b0;
      end else begin
         video_v1        <= video_valid_in;
         video_valid_out <= video_v1;
      end
   end

   chip8_fb_bram #(
      .DEPTH (FB_BYTES),
      .AW    (FB_ADDR_W)
   ) u_bram (
      .clk     (clk_in),
      .rst     (rst_in),
      .addr_a  (addr_a),
      .we_a    (we_a),
      .wdata_a (wdata_a),
      .q_a     (q_a),
      .addr_b  (video_addr_in[FB_ADDR_W-1:0]),
      .q_b     (video_data_out)
   );

endmodule

// File: tb/tb_chip8_framebuffer.sv
// tb_chip8_framebuffer: randomized bench with a byte-array screen model,
// checking processor responses, timing and the scanout port.
module tb_chip8_framebuffer;
   import chip8_pkg::*;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [11:0] proc_addr_in = '0;
   logic       proc_we_in = 1'b0;
   logic       proc_valid_in = 1'b0;
   logic [7:0] proc_data_in = '0;
   mem_type_t  proc_type_in = RAM;
   logic       proc_ready_out;
   logic       proc_valid_out;
   logic [7:0] data_out;
   logic       video_valid_in = 1'b0;
   logic [7:0] video_addr_in = '0;
   logic       video_valid_out;
   logic [7:0] video_data_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mdl [256];
   logic       mdl_flag = 1'b0;

   chip8_framebuffer dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .proc_addr_in    (proc_addr_in),
      .proc_we_in      (proc_we_in),
      .proc_valid_in   (proc_valid_in),
      .proc_data_in    (proc_data_in),
      .proc_type_in    (proc_type_in),
      .proc_ready_out  (proc_ready_out),
      .proc_valid_out  (proc_valid_out),
      .data_out        (data_out),
      .video_valid_in  (video_valid_in),
      .video_addr_in   (video_addr_in),
      .video_valid_out (video_valid_out),
      .video_data_out  (video_data_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // One processor transaction, checked against the screen model.
   task automatic do_op(input mem_type_t t, input logic we,
                        input logic [11:0] addr, input logic [7:0] d,
                        output logic [7:0] resp);
      logic [7:0] a;
      logic [7:0] want_d;
      int         want_lat;
      int         lat;
      logic       got;
      logic       rdy_bad;
      a        = addr[7:0];
      want_d   = 8'h00;
      want_lat = 2;
      got      = 1'b0;
      rdy_bad  = 1'b0;
      resp     = 8'h00;
      if (t == FB && !we) want_d = mdl[a];
      else if (t == FB) want_d = mdl[a] & d;
      else if (we && a == 8'd0) want_lat = 256;
      else if (!we && a == 8'd1) want_d = {7'b0, mdl_flag};
      @(posedge clk_in); #1;
      chk("rdy_idle", proc_ready_out, 1);
      proc_valid_in = 1'b1;
      proc_type_in  = t;
      proc_we_in    = we;
      proc_addr_in  = addr;
      proc_data_in  = d;
      @(posedge clk_in); #1;
      proc_valid_in = 1'b0;
      proc_addr_in  = 12'($urandom);
      proc_data_in  = 8'($urandom);
      proc_we_in    = 1'($urandom);
      proc_type_in  = mem_type_t'(2'($urandom));
      for (lat = 1; lat <= 400; lat++) begin
         @(negedge clk_in);
         if (proc_ready_out !== 1'b0) rdy_bad = 1'b1;
         if (proc_valid_out === 1'b1) begin
            got  = 1'b1;
            resp = data_out;
            break;
         end
         @(posedge clk_in); #1;
      end
      chk("resp_seen", got, 1);
      if (!got) return;
      chk("resp_lat", lat, want_lat);
      chk("resp_data", resp, want_d);
      chk("rdy_low", rdy_bad, 0);
      @(posedge clk_in);
      if (t == FB && we) begin
         if ((mdl[a] & d) != 8'h00) mdl_flag = 1'b1;
         mdl[a] = mdl[a] ^ d;
      end else if (t == FB_CTRL && we && a == 8'd0) begin
         for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
         mdl_flag = 1'b0;
      end else if (t == FB_CTRL && !we && a == 8'd1) begin
         mdl_flag = 1'b0;
      end
      #1;
      @(negedge clk_in);
      chk("rdy_back", proc_ready_out, 1);
      chk("one_pulse", proc_valid_out, 0);
   endtask

   task automatic vid_sweep(input int n, input int base, input int span);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in); #1;
         video_valid_in = 1'b1;
         video_addr_in  = 8'(base + (i % span));
      end
      @(posedge clk_in); #1;
      video_valid_in = 1'b0;
   endtask

   task automatic ignored_req(input mem_type_t t);
      logic bad;
      bad = 1'b0;
      @(posedge clk_in); #1;
      proc_type_in  = t;
      proc_valid_in = 1'b1;
      proc_we_in    = 1'($urandom);
      proc_addr_in  = 12'($urandom);
      proc_data_in  = 8'($urandom);
      repeat (4) begin
         @(negedge clk_in);
         if (proc_ready_out !== 1'b1 || proc_valid_out !== 1'b0) bad = 1'b1;
         @(posedge clk_in); #1;
      end
      proc_valid_in = 1'b0;
      @(negedge clk_in);
      if (proc_valid_out !== 1'b0) bad = 1'b1;
      chk("ignored_type", bad, 0);
   endtask

   // Scanout model: byte as seen by the model in the request cycle.
   initial begin
      logic       d1_v, d2_v;
      logic [7:0] d1_e, d2_e;
      d1_v = 1'b0; d2_v = 1'b0; d1_e = '0; d2_e = '0;
      forever begin
         @(negedge clk_in);
         if (!rst_in && (d2_v || video_valid_out)) begin
            chk("vid_valid", video_valid_out, d2_v);
            if (d2_v) chk("vid_data", video_data_out, d2_e);
         end
         d2_v = d1_v;
         d2_e = d1_e;
         d1_v = video_valid_in & !rst_in;
         d1_e = mdl[video_addr_in];
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r;
      for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
      repeat (3) @(posedge clk_in); #1;
      chk("rst_ready", proc_ready_out, 1);
      chk("rst_valid", proc_valid_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_vvalid", video_valid_out, 0);
      chk("rst_vdata", video_data_out, 0);
      @(negedge clk_in);
      rst_in = 1'b0;

      do_op(FB_CTRL, 1'b1, 12'h000, 8'h00, r);
      do_op(FB, 1'b1, 12'h005, 8'h3C, r);
      chk("w5_ack", r, 8'h00);
      do_op(FB, 1'b0, 12'h005, 8'h00, r);
      chk("rd5", r, 8'h3C);

      do_op(FB, 1'b1, 12'h010, 8'h3C, r);
      do_op(FB, 1'b1, 12'h010, 8'hF0, r);
      chk("rmw_off", r, 8'h30);
      do_op(FB, 1'b0, 12'h010, 8'h00, r);
      chk("rmw_xor", r, 8'hCC);
      do_op(FB_CTRL, 1'b0, 12'h001, 8'h00, r);
      chk("flag_set", r, 8'h01);
      do_op(FB_CTRL, 1'b0, 12'h001, 8'h00, r);
      chk("flag_clr", r, 8'h00);

      do_op(FB, 1'b1, 12'h020, 8'hF0, r);
      do_op(FB, 1'b1, 12'h020, 8'h0F, r);
      chk("no_coll_ack", r, 8'h00);
      do_op(FB_CTRL, 1'b0, 12'h001, 8'h00, r);
      chk("no_coll_flag", r, 8'h00);

      do_op(FB, 1'b1, 12'h1FF, 8'h5A, r);
      do_op(FB, 1'b0, 12'h0FF, 8'h00, r);
      chk("addr_wrap", r, 8'h5A);

      ignored_req(RAM);
      ignored_req(RSVD);

      vid_sweep(32, 0, 32);
      fork
         vid_sweep(48, 0, 16);
         begin
            repeat (4) do_op(FB, 1'b1, 12'h003, 8'($urandom), r);
            do_op(FB, 1'b0, 12'h003, 8'h00, r);
         end
      join

      for (int i = 0; i < 256; i++)
         do_op(FB, 1'b1, 12'(i), mdl[i] ^ 8'hFF, r);
      vid_sweep(8, 248, 8);
      do_op(FB_CTRL, 1'b1, 12'h000, 8'h00, r);
      vid_sweep(256, 0, 256);
      do_op(FB_CTRL, 1'b0, 12'h001, 8'h00, r);
      chk("clr_flag", r, 8'h00);

      for (int n = 0; n < 80; n++) begin
         int k;
         k = $urandom_range(0, 9);
         if (k < 5)
            do_op(FB, 1'b1, 12'($urandom), 8'($urandom), r);
         else if (k < 8)
            do_op(FB, 1'b0, 12'($urandom), 8'h00, r);
         else if (k == 8)
            do_op(FB_CTRL, 1'b0, 12'h001, 8'h00, r);
         else
            do_op(FB_CTRL, 1'($urandom),
                  12'($urandom_range(2, 255)), 8'($urandom), r);
      end
      vid_sweep(64, 0, 64);

      @(posedge clk_in); #1;
      proc_type_in  = FB_CTRL;
      proc_we_in    = 1'b1;
      proc_addr_in  = 12'h000;
      proc_valid_in = 1'b1;
      @(posedge clk_in); #1;
      proc_valid_in = 1'b0;
      repeat (99) @(posedge clk_in);
      #1;
      chk("mid_clr_busy", proc_ready_out, 0);
      rst_in = 1'b1;
      #1;
      chk("rst2_ready", proc_ready_out, 1);
      chk("rst2_valid", proc_valid_out, 0);
      chk("rst2_data", data_out, 0);
      chk("rst2_vvalid", video_valid_out, 0);
      chk("rst2_vdata", video_data_out, 0);
      mdl_flag = 1'b0;
      begin
         logic seen;
         seen = 1'b0;
         repeat (4) begin
            @(negedge clk_in);
            if (proc_valid_out !== 1'b0) seen = 1'b1;
         end
         rst_in = 1'b0;
         repeat (200) begin
            @(negedge clk_in);
            if (proc_valid_out !== 1'b0) seen = 1'b1;
         end
         chk("no_ack_rst", seen, 0);
      end
      do_op(FB_CTRL, 1'b1, 12'h000, 8'h00, r);
      do_op(FB, 1'b1, 12'h07E, 8'hA5, r);
      do_op(FB, 1'b0, 12'h07E, 8'h00, r);
      chk("post_rst_rd", r, 8'hA5);
      vid_sweep(16, 120, 16);

      repeat (4) @(posedge clk_in);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
